eth_tx_framer: RTL and testbench
================================

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 Parameter DATA_W, default 32, input word width in bits; legal values 8, 16, 32.
REQ-002 Parameter DEPTH, default 512, frame buffer depth in words; power of two.
REQ-003 Parameter MIN_LEN, default 60, minimum payload bytes before FCS; 0 disables padding.
REQ-004 Parameter IFG_CYCLES, default 48, idle clocks after FCS.
REQ-005 clk_50_mhz  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 s_data  input  DATA_W  payload word; first byte is s_data[DATA_W-1 -: 8].
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_last  input  1  word is last of frame.
REQ-010 s_bytes  input  max(1,$clog2(DATA_W/8))  valid bytes in last word minus one; ignored unless s_last.
REQ-011 s_ready  output  1  framer accepts a word this cycle.
REQ-012 send  input  1  start transmission of the buffered frame.
REQ-013 ready_to_send  output  1  complete frame buffered, awaiting send.
REQ-014 m_data  output  8  byte to serializer.
REQ-015 m_valid  output  1  m_data valid.
REQ-016 m_ready  input  1  serializer consumed byte (transmitter done_o).
REQ-017 m_last  output  1  current byte is final FCS byte.
REQ-018 done  output  1  one-cycle pulse when IFG ends.
REQ-019 overflow  output  1  one-cycle pulse when a frame exceeds DEPTH words and is dropped.

Function
REQ-020 A word transfers when s_valid && s_ready; byte transfers when m_valid && m_ready.
REQ-021 s_ready SHALL be high only in state LOAD.
REQ-022 States: LOAD, WAIT, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG.
REQ-023 LOAD: accepted words written to buffer; accepted s_last moves to WAIT, ready_to_send=1 next cycle.
REQ-024 A word accepted with the buffer full and s_last low SHALL discard the frame, pulse overflow, stay in LOAD with write pointer reset.
REQ-025 WAIT: send high moves to PREAMBLE and clears ready_to_send; send in any other state is ignored.
REQ-026 PREAMBLE: seven bytes 0x55; SFD: one byte 0xD5.
REQ-027 PAYLOAD: buffered bytes in write order, MSB byte of each word first, last word truncated per s_bytes.
REQ-028 PAD: 0x00 bytes until payload+pad count equals MIN_LEN; skipped if payload >= MIN_LEN.
REQ-029 FCS: IEEE 802.3 CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, final complement) over payload and pad, four bytes, least-significant byte first; m_last on fourth.
REQ-030 CRC updates on each transferred payload/pad byte only; preamble/SFD excluded.
REQ-031 m_data, m_last SHALL hold stable while m_valid && !m_ready; m_valid SHALL stay high until transfer.
REQ-032 Next byte presented the cycle after a transfer (one-cycle bubble permitted, none required).
REQ-033 IFG: m_valid low for IFG_CYCLES clocks, then done pulse, return to LOAD with buffer empty.
REQ-034 Byte counter width covers DEPTH*DATA_W/8; no wrap within a legal frame.

Reset
REQ-035 rst_n low SHALL immediately force state LOAD, pointers/counters zero, CRC 0xFFFFFFFF.
REQ-036 Reset values: s_ready 0 while rst_n low then 1, ready_to_send 0, m_valid 0, m_data 0x00, m_last 0, done 0, overflow 0.
REQ-037 Reset mid-frame SHALL abandon it; no residual byte emitted after release.

Structure
REQ-038 Package eth_pkg SHALL hold state enum, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY, CRC_INIT.
REQ-039 CRC SHALL be sub-module eth_crc32 (byte-wide, clear/enable inputs); buffer inferred RAM inside framer.

Verification
REQ-040 DATA_W=32, MIN_LEN=0: frame ASCII "123456789" (3 words, s_bytes=0 on last) -> 55x7, D5, 31..39, FCS 26 39 F4 CB, m_last on CB.
REQ-041 DATA_W=32, MIN_LEN=60: single word 0xDEADBEEF s_bytes=3 -> DE AD BE EF, 56 x 00, FCS; 72 bytes total, done 48 cycles after last.
REQ-042 m_ready toggled randomly 30% -> identical byte stream as REQ-041, m_data stable on every stall.
REQ-043 DEPTH=16: 17 words without s_last -> overflow pulse once, ready_to_send stays 0, next 2-word frame transmits correctly.
REQ-044 rst_n low during PAYLOAD byte 10 -> m_valid 0 same cycle; after release, send ignored, new frame transmits cleanly.
REQ-045 DATA_W=8 and 16 rerun of REQ-040 -> identical output bytes and FCS.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX framer and its CRC-32 engine.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_WAIT,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam int          PREAMBLE_LEN  = 7;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected IEEE 802.3 CRC-32; fcs is the complemented register,
// ready to be sent least-significant byte first.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] fcs
);

  localparam logic [31:0] POLY_REFL = bit_rev32(CRC_POLY);

  logic [31:0] crc, crc_next;

  always_comb begin
    crc_next = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++)
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ POLY_REFL) : (crc_next >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc_next;
  end

  assign fcs = ~crc;

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: buffers one frame of DATA_W-bit words, then emits preamble,
// SFD, payload, zero pad, CRC-32 FCS and an inter-frame gap as a byte stream.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  DEPTH      = 512,
  parameter int  MIN_LEN    = 60,
  parameter int  IFG_CYCLES = 48,
  localparam int SBW        = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
  input  logic              clk_50_mhz,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  input  logic [SBW-1:0]    s_bytes,
  output logic              s_ready,
  input  logic              send,
  output logic              ready_to_send,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              done,
  output logic              overflow
);

  localparam int BPW   = DATA_W / 8;
  localparam int LB    = $clog2(BPW);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH * BPW + MIN_LEN + 1);
  localparam int IFG_N = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
  localparam int GW    = $clog2(IFG_N + 8);

  state_t            state, state_next;
  logic [AW:0]       wr_cnt;
  logic [CW-1:0]     frame_len, tx_cnt, last_len, lane;
  logic [GW-1:0]     gen_cnt;
  logic              overflow_r;
  logic              accept, full, xfer, start, gen_en, crc_en;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word, rd_shift;
  logic [AW-1:0]     rd_addr;
  logic [31:0]       fcs;

  assign s_ready       = (state == ST_LOAD) && rst_n;
  assign accept        = s_valid && s_ready;
  assign full          = wr_cnt[AW];
  assign xfer          = m_valid && m_ready;
  assign start         = (state == ST_WAIT) && send;
  assign crc_en        = xfer && ((state == ST_PAYLOAD) || (state == ST_PAD));
  assign gen_en        = (xfer && ((state == ST_PREAMBLE) || (state == ST_FCS))) || (state == ST_IFG);
  assign ready_to_send = (state == ST_WAIT);
  assign overflow      = overflow_r;
  assign done          = (state == ST_IFG) && (gen_cnt == GW'(IFG_N - 1));

  // Byte length of the frame once its last word arrives; s_bytes is meaningless for 8-bit words.
  assign last_len = (CW'(wr_cnt) << LB) + (CW'(s_bytes) & CW'(BPW - 1)) + CW'(1);

  assign rd_addr  = AW'(tx_cnt >> LB);
  assign rd_word  = mem[rd_addr];
  assign lane     = tx_cnt & CW'(BPW - 1);
  assign rd_shift = rd_word << {lane, 3'b000};

  always_ff @(posedge clk_50_mhz) begin
    if (accept && !full) mem[wr_cnt[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk_50_mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      wr_cnt     <= '0;
      frame_len  <= '0;
      tx_cnt     <= '0;
      gen_cnt    <= '0;
      overflow_r <= 1'b0;
    end else begin
      state      <= state_next;
      overflow_r <= accept && full;
      if (accept) begin
        // A word arriving with the buffer already full drops the whole frame.
        if (full) wr_cnt <= '0;
        else      wr_cnt <= wr_cnt + (AW + 1)'(1);
        if (!full && s_last) frame_len <= last_len;
      end else if (start) begin
        wr_cnt <= '0;
      end
      if (start)       tx_cnt <= '0;
      else if (crc_en) tx_cnt <= tx_cnt + CW'(1);
      if (state_next != state) gen_cnt <= '0;
      else if (gen_en)         gen_cnt <= gen_cnt + GW'(1);
    end
  end

  always_comb begin
    state_next = state;
    m_valid    = 1'b0;
    m_data     = 8'h00;
    m_last     = 1'b0;
    case (state)
      ST_LOAD: if (accept && !full && s_last) state_next = ST_WAIT;
      ST_WAIT: if (send) state_next = ST_PREAMBLE;
      ST_PREAMBLE: begin
        m_valid = 1'b1;
        m_data  = PREAMBLE_BYTE;
        if (xfer && (gen_cnt == GW'(PREAMBLE_LEN - 1))) state_next = ST_SFD;
      end
      ST_SFD: begin
        m_valid = 1'b1;
        m_data  = SFD_BYTE;
        if (xfer) state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        m_valid = 1'b1;
        m_data  = rd_shift[DATA_W-1 -: 8];
        if (xfer && (tx_cnt == frame_len - CW'(1)))
          state_next = (frame_len < CW'(MIN_LEN)) ? ST_PAD : ST_FCS;
      end
      ST_PAD: begin
        m_valid = 1'b1;
        if (xfer && (tx_cnt == CW'(MIN_LEN - 1))) state_next = ST_FCS;
      end
      ST_FCS: begin
        m_valid = 1'b1;
        m_data  = 8'(fcs >> {gen_cnt[1:0], 3'b000});
        m_last  = (gen_cnt == GW'(3));
        if (xfer && m_last) state_next = ST_IFG;
      end
      ST_IFG: if (gen_cnt == GW'(IFG_N - 1)) state_next = ST_LOAD;
      default: state_next = ST_LOAD;
    endcase
  end

  eth_crc32 u_crc (
    .clk   (clk_50_mhz),
    .rst_n (rst_n),
    .clr   (start),
    .en    (crc_en),
    .data  (m_data),
    .fcs   (fcs)
  );

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: a 32-bit padded instance and an 8-bit unpadded instance
// checked byte-by-byte against a queue of expected frames.
module tb_eth_tx_framer;

  typedef logic [7:0] u8_t;
  typedef u8_t bq_t[$];
  typedef struct packed { logic last; logic [7:0] d; } exp_t;
  typedef struct { int sel; int len; int first; int step; int pct; int total; } vec_t;

  localparam int A_MIN = 60;
  localparam int A_IFG = 48;
  localparam int B_MIN = 0;
  localparam int B_IFG = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_s_data;
  logic        a_s_valid, a_s_last, a_s_ready, a_send, a_rts;
  logic [1:0]  a_s_bytes;
  logic [7:0]  a_m_data;
  logic        a_m_valid, a_m_ready, a_m_last, a_done, a_overflow;

  logic [7:0]  b_s_data;
  logic        b_s_valid, b_s_last, b_s_ready, b_send, b_rts;
  logic [0:0]  b_s_bytes;
  logic [7:0]  b_m_data;
  logic        b_m_valid, b_m_ready, b_m_last, b_done, b_overflow;

  eth_tx_framer #(.DATA_W(32), .DEPTH(16), .MIN_LEN(A_MIN), .IFG_CYCLES(A_IFG)) dut_a (
    .clk_50_mhz(clk), .rst_n(rst_n), .s_data(a_s_data), .s_valid(a_s_valid),
    .s_last(a_s_last), .s_bytes(a_s_bytes), .s_ready(a_s_ready), .send(a_send),
    .ready_to_send(a_rts), .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .m_last(a_m_last), .done(a_done), .overflow(a_overflow));

  eth_tx_framer #(.DATA_W(8), .DEPTH(16), .MIN_LEN(B_MIN), .IFG_CYCLES(B_IFG)) dut_b (
    .clk_50_mhz(clk), .rst_n(rst_n), .s_data(b_s_data), .s_valid(b_s_valid),
    .s_last(b_s_last), .s_bytes(b_s_bytes), .s_ready(b_s_ready), .send(b_send),
    .ready_to_send(b_rts), .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_last(b_m_last), .done(b_done), .overflow(b_overflow));

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   xfers[2], done_cnt[2], last_cyc[2], done_cyc[2], ovf_cnt[2];
  logic stall_prev[2], prev_last[2], acc[2];
  logic [7:0] prev_data[2];
  exp_t exp_a[$], exp_b[$];
  string nm[2] = '{"a", "b"};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc_ref(input bq_t q);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (q[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  function automatic bq_t frame_bytes(input bq_t pl, input int min_len);
    bq_t f, body;
    logic [31:0] c;
    body = pl;
    while (body.size() < min_len) body.push_back(8'h00);
    c = crc_ref(body);
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    foreach (body[i]) f.push_back(body[i]);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    return f;
  endfunction

  task automatic push_exp(input int sel, input bq_t f);
    exp_t e;
    foreach (f[i]) begin
      e.d    = f[i];
      e.last = (i == f.size() - 1);
      if (sel == 0) exp_a.push_back(e);
      else          exp_b.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      logic v, r, l, dn, ov;
      logic [7:0] d;
      v  = (i == 0) ? a_m_valid : b_m_valid;
      r  = (i == 0) ? a_m_ready : b_m_ready;
      l  = (i == 0) ? a_m_last  : b_m_last;
      d  = (i == 0) ? a_m_data  : b_m_data;
      dn = (i == 0) ? a_done    : b_done;
      ov = (i == 0) ? a_overflow : b_overflow;
      acc[i] = (i == 0) ? (a_s_valid && a_s_ready) : (b_s_valid && b_s_ready);
      if (!rst_n) begin
        stall_prev[i] = 1'b0;
        continue;
      end
      if (stall_prev[i])
        chk($sformatf("%s_stall_hold", nm[i]), {v, l, d}, {1'b1, prev_last[i], prev_data[i]});
      if (v && r) begin
        if ((i == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL %s_extra_byte: got 0x%0h, required no byte", nm[i], d);
        end else begin
          e = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
          chk($sformatf("%s_byte%0d", nm[i], xfers[i]), {l, d}, e);
        end
        xfers[i]++;
        if (l) last_cyc[i] = cyc;
      end
      if (dn) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      if (ov) ovf_cnt[i]++;
      stall_prev[i] = v && !r;
      prev_data[i]  = d;
      prev_last[i]  = l;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_send(input int sel, input logic v);
    if (sel == 0) a_send = v; else b_send = v;
  endtask

  task automatic drive_mready(input int sel, input logic v);
    if (sel == 0) a_m_ready = v; else b_m_ready = v;
  endtask

  task automatic load(input int sel, input bq_t pl);
    int bpw, nw, guard;
    logic [31:0] word;
    bpw = (sel == 0) ? 4 : 1;
    nw  = (pl.size() + bpw - 1) / bpw;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < bpw; k++) begin
        word = word << 8;
        if (w * bpw + k < pl.size()) word[7:0] = pl[w * bpw + k];
      end
      if (sel == 0) begin
        a_s_data = word; a_s_valid = 1'b1; a_s_last = (w == nw - 1);
        a_s_bytes = 2'((pl.size() - 1) % 4);
      end else begin
        b_s_data = word[7:0]; b_s_valid = 1'b1; b_s_last = (w == nw - 1);
        b_s_bytes = 1'b0;
      end
      tick();
      guard = 0;
      while (!acc[sel] && guard < 20) begin
        tick();
        guard++;
      end
      if (!acc[sel]) chk($sformatf("%s_load_accept", nm[sel]), acc[sel], 1);
    end
    a_s_valid = 1'b0; a_s_last = 1'b0;
    b_s_valid = 1'b0; b_s_last = 1'b0;
  endtask

  task automatic xmit(input int sel, input int pct, input int total_bytes);
    int x0, d0, guard;
    chk($sformatf("%s_rts_set", nm[sel]), (sel == 0) ? a_rts : b_rts, 1);
    x0 = xfers[sel];
    d0 = done_cnt[sel];
    drive_send(sel, 1'b1);
    tick();
    drive_send(sel, 1'b0);
    chk($sformatf("%s_rts_clear", nm[sel]), (sel == 0) ? a_rts : b_rts, 0);
    chk($sformatf("%s_s_ready_busy", nm[sel]), (sel == 0) ? a_s_ready : b_s_ready, 0);
    guard = 0;
    while (done_cnt[sel] == d0 && guard < 3000) begin
      drive_mready(sel, $urandom_range(0, 99) >= pct);
      tick();
      guard++;
    end
    drive_mready(sel, 1'b1);
    chk($sformatf("%s_done_pulses", nm[sel]), done_cnt[sel] - d0, 1);
    chk($sformatf("%s_frame_bytes", nm[sel]), xfers[sel] - x0, total_bytes);
    chk($sformatf("%s_exp_left", nm[sel]), (sel == 0) ? exp_a.size() : exp_b.size(), 0);
    chk($sformatf("%s_ifg_gap", nm[sel]), done_cyc[sel] - last_cyc[sel], (sel == 0) ? A_IFG : B_IFG);
    tick();
    chk($sformatf("%s_s_ready_back", nm[sel]), (sel == 0) ? a_s_ready : b_s_ready, 1);
  endtask

  task automatic run_frame(input int sel, input bq_t pl, input int pct, input int total_bytes);
    load(sel, pl);
    push_exp(sel, frame_bytes(pl, (sel == 0) ? A_MIN : B_MIN));
    xmit(sel, pct, total_bytes);
  endtask

  initial begin
    vec_t vt[7];
    bq_t  pl, f;
    int   x0, o0, guard;

    vt[0] = '{0,  9, 'h31,  1,  0, 72};
    vt[1] = '{0, 61, 'h10,  3, 30, 73};
    vt[2] = '{0, 60, 'hA0,  7,  0, 72};
    vt[3] = '{0,  5, 'h01,  1, 50, 72};
    vt[4] = '{1,  9, 'h31,  1,  0, 21};
    vt[5] = '{1,  1, 'hFF,  0, 30, 13};
    vt[6] = '{1, 16, 'h00, 17, 30, 28};

    for (int i = 0; i < 2; i++) begin
      xfers[i] = 0; done_cnt[i] = 0; last_cyc[i] = 0; done_cyc[i] = 0; ovf_cnt[i] = 0;
      stall_prev[i] = 1'b0; prev_last[i] = 1'b0; prev_data[i] = 8'h00; acc[i] = 1'b0;
    end
    a_s_data = '0; a_s_valid = 0; a_s_last = 0; a_s_bytes = '0; a_send = 0; a_m_ready = 1;
    b_s_data = '0; b_s_valid = 0; b_s_last = 0; b_s_bytes = '0; b_send = 0; b_m_ready = 1;

    // Asynchronous reset takes effect before the first clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_ready", a_s_ready, 0);
    chk("rst_rts", a_rts, 0);
    chk("rst_m_valid", a_m_valid, 0);
    chk("rst_m_data", a_m_data, 8'h00);
    chk("rst_m_last", a_m_last, 0);
    chk("rst_done", a_done, 0);
    chk("rst_overflow", a_overflow, 0);
    chk("rst_b_m_valid", b_m_valid, 0);
    tick();
    tick();
    chk("rst_s_ready_held", a_s_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", a_s_ready, 1);
    chk("rel_b_s_ready", b_s_ready, 1);
    tick();

    // 8-bit instance, no padding: the standard check string.
    pl = {};
    for (int k = 0; k < 9; k++) pl.push_back(u8_t'(8'h31 + k));
    load(1, pl);
    f = {};
    for (int k = 0; k < 7; k++) f.push_back(8'h55);
    f.push_back(8'hD5);
    foreach (pl[k]) f.push_back(pl[k]);
    f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(8'hCB);
    push_exp(1, f);
    xmit(1, 0, 21);

    // Single partial-free word padded to the minimum, then the same with stalls.
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(0, pl, 0, 72);
    run_frame(0, pl, 30, 72);

    foreach (vt[i]) begin
      pl = {};
      for (int k = 0; k < vt[i].len; k++) pl.push_back(u8_t'(vt[i].first + k * vt[i].step));
      run_frame(vt[i].sel, pl, vt[i].pct, vt[i].total);
    end

    // Overflow: 17 words into a 16-word buffer without s_last.
    o0 = ovf_cnt[0];
    for (int w = 0; w < 17; w++) begin
      a_s_data = $urandom; a_s_valid = 1'b1; a_s_last = 1'b0;
      tick();
    end
    a_s_valid = 1'b0;
    tick();
    tick();
    chk("ovf_pulses", ovf_cnt[0] - o0, 1);
    chk("ovf_rts", a_rts, 0);
    chk("ovf_s_ready", a_s_ready, 1);
    pl = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76};
    run_frame(0, pl, 0, 72);

    // Reset while the tenth payload byte is on the bus.
    pl = {};
    for (int k = 0; k < 20; k++) pl.push_back(u8_t'(8'h40 + k));
    load(0, pl);
    push_exp(0, frame_bytes(pl, A_MIN));
    x0 = xfers[0];
    a_send = 1'b1;
    tick();
    a_send = 1'b0;
    guard = 0;
    while (xfers[0] - x0 < 17 && guard < 200) begin
      tick();
      guard++;
    end
    chk("mid_valid_before", a_m_valid, 1);
    chk("mid_byte10", a_m_data, pl[9]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", a_m_valid, 0);
    chk("mid_rst_m_data", a_m_data, 8'h00);
    exp_a.delete();
    tick();
    rst_n = 1'b1;
    x0 = xfers[0];
    a_send = 1'b1;
    tick();
    a_send = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("post_rst_no_bytes", xfers[0] - x0, 0);
    chk("post_rst_rts", a_rts, 0);
    pl = '{8'hC0, 8'hFF, 8'hEE, 8'h01, 8'h02};
    run_frame(0, pl, 30, 72);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
